imm_encoder: RTL and testbench

//  Inverse of the immediate generator: packs a 32-bit immediate into the imm fields of an

---
 rtl/imm_encoder.sv | 155 +++++++++++++++
 tb/tb_imm_encoder.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate into an instruction template, two-stage valid/ready pipe.
// Define IMM_ENC_STATS_EN to add saturating emitted/error word counters.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_template,
  input  logic [31:0]      io_in_imm,
  input  logic [2:0]       io_in_imm_type,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [31:0]      io_out_instruction,
  output logic             io_out_range_err,
  output logic             io_err_sticky
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] io_enc_count,
  output logic [CNT_W-1:0] io_err_count
`endif
);

  localparam logic [2:0] T_I  = 3'd1;
  localparam logic [2:0] T_U  = 3'd2;
  localparam logic [2:0] T_C4 = 3'd3;
  localparam logic [2:0] T_S  = 3'd4;
  localparam logic [2:0] T_SH = 3'd5;
  localparam logic [2:0] T_IZ = 3'd6;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic        r_s1_valid;
  logic [31:0] r_s1_tpl;
  logic [31:0] r_s1_imm;
  logic [2:0]  r_s1_type;
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;
  logic        r_sticky;

  logic        w_s1_ready;
  logic        w_s2_ready;
  logic        w_out_hs;
  logic        w_simm_ok;
  logic [31:0] w_enc;
  logic        w_err;

  assign w_s2_ready = !r_s2_valid | io_out_ready;
  assign w_s1_ready = !r_s1_valid | w_s2_ready;
  assign w_out_hs   = r_s2_valid & io_out_ready;

  assign io_in_ready        = w_s1_ready;
  assign io_out_valid       = r_s2_valid;
  assign io_out_instruction = r_s2_instr;
  assign io_out_range_err   = r_s2_err;
  assign io_err_sticky      = r_sticky;

  // 12-bit signed fits iff bits 31..11 are a pure sign extension
  assign w_simm_ok = (&r_s1_imm[31:11]) | ~(|r_s1_imm[31:11]);

  always_comb begin
    w_enc = r_s1_tpl;
    w_err = 1'b0;
    case (r_s1_type)
      T_I: begin
        w_enc = {r_s1_imm[11:0], r_s1_tpl[19:0]};
        w_err = !w_simm_ok;
      end
      T_IZ: begin
        w_enc = {r_s1_imm[11:0], r_s1_tpl[19:0]};
        w_err = |r_s1_imm[31:12];
      end
      T_U: begin
        w_enc = {r_s1_imm[31:12], r_s1_tpl[11:0]};
        w_err = |r_s1_imm[11:0];
      end
      T_C4: begin
        w_err = (r_s1_imm != 32'd4);
      end
      T_S: begin
        w_enc = {r_s1_imm[11:5], r_s1_tpl[24:12],
                 r_s1_imm[4:0], r_s1_tpl[6:0]};
        w_err = !w_simm_ok;
      end
      T_SH: begin
        w_enc = {r_s1_tpl[31:25], r_s1_imm[4:0],
                 r_s1_tpl[19:0]};
        w_err = |r_s1_imm[31:5];
      end
      default: begin
        w_enc = r_s1_tpl;
        w_err = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_tpl   <= '0;
      r_s1_imm   <= '0;
      r_s1_type  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= io_in_valid;
        if (io_in_valid) begin
          r_s1_tpl  <= io_in_template;
          r_s1_imm  <= io_in_imm;
          r_s1_type <= io_in_imm_type;
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_enc;
          r_s2_err   <= w_err;
        end
      end
      if (w_out_hs & r_s2_err) begin
        r_sticky <= 1'b1;
      end
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_enc_cnt != '1) begin
        r_enc_cnt <= r_enc_cnt + 1'b1;
      end
      if (r_s2_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign io_enc_count = r_enc_cnt;
  assign io_err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against a queue model.
// Define IMM_ENC_STATS_EN to also exercise the statistics counters (CNT_W=4).
module tb_imm_encoder;

`ifdef IMM_ENC_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [31:0]   io_in_template;
  logic [31:0]   io_in_imm;
  logic [2:0]    io_in_imm_type;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [31:0]   io_out_instruction;
  logic          io_out_range_err;
  logic          io_err_sticky;
`ifdef IMM_ENC_STATS_EN
  logic [CW-1:0] io_enc_count;
  logic [CW-1:0] io_err_count;
`endif

  always #5 clock = ~clock;

  imm_encoder #(.CNT_W(CW)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_template     (io_in_template),
    .io_in_imm          (io_in_imm),
    .io_in_imm_type     (io_in_imm_type),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_instruction (io_out_instruction),
    .io_out_range_err   (io_out_range_err),
    .io_err_sticky      (io_err_sticky)
`ifdef IMM_ENC_STATS_EN
    ,
    .io_enc_count       (io_enc_count),
    .io_err_count       (io_err_count)
`endif
  );

  typedef struct packed {
    logic        v;
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_sticky;
  int   exp_enc;
  int   exp_errc;

  function automatic exp_t model(input logic [31:0] t,
                                 input logic [31:0] i,
                                 input logic [2:0]  ty);
    exp_t r;
    int   s;
    s   = $signed(i);
    r.v = 1'b1;
    r.w = t;
    r.e = 1'b0;
    case (ty)
      3'd1, 3'd6: r.w = (t & 32'h000F_FFFF) | ((i & 32'hFFF) << 20);
      3'd2:       r.w = (t & 32'h0000_0FFF) | (i & 32'hFFFF_F000);
      3'd4:       r.w = (t & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25)
                        | ((i & 32'h1F) << 7);
      3'd5:       r.w = (t & 32'hFE0F_FFFF) | ((i & 32'h1F) << 20);
      default:    r.w = t;
    endcase
    case (ty)
      3'd1, 3'd4: r.e = (s < -2048) || (s > 2047);
      3'd2:       r.e = (i % 4096) != 0;
      3'd3:       r.e = (i != 4);
      3'd5:       r.e = (i > 31);
      3'd6:       r.e = (i > 4095);
      default:    r.e = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'hFFFF_F800 + 32'($urandom_range(0, 4095));
      2:       return $urandom;
      3:       return $urandom & 32'hFFFF_F000;
      4:       return 32'($urandom_range(0, 5000));
      default: return 32'h0000_07F0 + 32'($urandom_range(0, 32));
    endcase
  endfunction

  // Advance one clock; record handshakes into the model queue.
  task automatic step(output bit hs, output logic [31:0] ow,
                      output logic oe, output exp_t ex);
    bit ih;
    #1;
    ih = io_in_valid && io_in_ready;
    hs = io_out_valid && io_out_ready;
    ow = io_out_instruction;
    oe = io_out_range_err;
    ex = '0;
    if (hs && q.size() > 0) ex = q.pop_front();
    if (ih) q.push_back(model(io_in_template, io_in_imm, io_in_imm_type));
    if (hs && ex.v) begin
      if (ex.e) exp_sticky = 1'b1;
      if (exp_enc < CMAX) exp_enc++;
      if (ex.e && exp_errc < CMAX) exp_errc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    q.delete();
    exp_sticky = 1'b0;
    exp_enc    = 0;
    exp_errc   = 0;
  endtask

  task automatic test_reset();
    io_in_template = '0;
    io_in_imm      = '0;
    io_in_imm_type = '0;
    do_reset();
    #1;
    checks++;
    if (io_out_valid !== 1'b0 || io_out_instruction !== 32'h0 ||
        io_out_range_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b instr=%h err=%b required 0/0/0",
               io_out_valid, io_out_instruction, io_out_range_err);
    end
    checks++;
    if (io_err_sticky !== 1'b0 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: sticky=%b in_ready=%b required 0/1",
               io_err_sticky, io_in_ready);
    end
`ifdef IMM_ENC_STATS_EN
    checks++;
    if (io_enc_count !== '0 || io_err_count !== '0) begin
      errors++;
      $display("FAIL reset_cnt: enc=%0d err=%0d required 0/0",
               io_enc_count, io_err_count);
    end
`endif
  endtask

  task automatic test_latency();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    io_out_ready   = 1'b1;
    io_in_valid    = 1'b1;
    io_in_template = 32'h0000_0013;
    io_in_imm      = 32'hFFFF_F800;
    io_in_imm_type = 3'd1;
    step(hs, ow, oe, ex);
    io_in_valid = 1'b0;
    #1;
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_early: out_valid=%b required 0", io_out_valid);
    end
    step(hs, ow, oe, ex);
    checks++;
    if (io_out_valid !== 1'b1 || io_out_instruction !== 32'h8000_0013 ||
        io_out_range_err !== 1'b0) begin
      errors++;
      $display("FAIL t1_word: valid=%b instr=%h err=%b required 1/80000013/0",
               io_out_valid, io_out_instruction, io_out_range_err);
    end
    step(hs, ow, oe, ex);
    checks++;
    if (!hs || !ex.v || ow !== ex.w || oe !== ex.e) begin
      errors++;
      $display("FAIL t1_drain: hs=%b got %h/%b required %h/%b",
               hs, ow, oe, ex.w, ex.e);
    end
  endtask

  task automatic test_s_type_err();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    bit done;
    done = 1'b0;
    io_out_ready   = 1'b1;
    io_in_valid    = 1'b1;
    io_in_template = 32'h0000_2023;
    io_in_imm      = 32'h0000_0FFF;
    io_in_imm_type = 3'd4;
    step(hs, ow, oe, ex);
    io_in_valid = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      step(hs, ow, oe, ex);
      if (hs) begin
        done = 1'b1;
        checks++;
        if (ow !== 32'hFE00_2FA3 || oe !== 1'b1) begin
          errors++;
          $display("FAIL t2_word: got %h/%b required fe002fa3/1", ow, oe);
        end
        checks++;
        if (io_err_sticky !== 1'b1) begin
          errors++;
          $display("FAIL t2_sticky: got %b required 1", io_err_sticky);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL t2_timeout: no output within bound");
    end
  endtask

  task automatic test_back_to_back();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    logic [31:0] rw[2];
    logic        re[2];
    int          n;
    n = 0;
    io_out_ready   = 1'b1;
    io_in_valid    = 1'b1;
    io_in_template = 32'h0000_0537;
    io_in_imm      = 32'h1234_5000;
    io_in_imm_type = 3'd2;
    step(hs, ow, oe, ex);
    io_in_imm = 32'h1234_5001;
    step(hs, ow, oe, ex);
    io_in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(hs, ow, oe, ex);
      if (hs && n < 2) begin
        rw[n] = ow;
        re[n] = oe;
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL t3_count: got %0d words required 2", n);
    end else begin
      checks++;
      if (rw[0] !== 32'h1234_5537 || re[0] !== 1'b0) begin
        errors++;
        $display("FAIL t3_ok: got %h/%b required 12345537/0", rw[0], re[0]);
      end
      checks++;
      if (rw[1] !== 32'h1234_5537 || re[1] !== 1'b1) begin
        errors++;
        $display("FAIL t3_err: got %h/%b required 12345537/1", rw[1], re[1]);
      end
    end
  endtask

  task automatic test_stream_stall();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          k, got, full_seen;
    bit          stalled;
    logic [31:0] sw;
    logic        se;
    do_reset();
    k = 0; got = 0; full_seen = 0;
    io_in_valid    = 1'b1;
    io_in_imm_type = 3'd5;
    io_in_imm      = 32'd0;
    io_in_template = $urandom;
    for (int c = 0; c < 80 && got < 8; c++) begin
      io_out_ready = pat[c % 4];
      #1;
      checks++;
      if (io_in_ready !== !(q.size() == 2 && !io_out_ready)) begin
        errors++;
        $display("FAIL t4_in_ready: got %b with %0d in flight ready_out=%b",
                 io_in_ready, q.size(), io_out_ready);
      end
      if (!io_in_ready) full_seen++;
      stalled = io_out_valid && !io_out_ready;
      sw = io_out_instruction;
      se = io_out_range_err;
      if (io_in_valid && io_in_ready) k++;
      step(hs, ow, oe, ex);
      if (stalled) begin
        checks++;
        if (io_out_valid !== 1'b1 || io_out_instruction !== sw ||
            io_out_range_err !== se) begin
          errors++;
          $display("FAIL t4_stable: got %b/%h/%b required 1/%h/%b",
                   io_out_valid, io_out_instruction, io_out_range_err, sw, se);
        end
      end
      if (hs) begin
        checks++;
        if (!ex.v || ow !== ex.w || oe !== ex.e ||
            ((ow >> 20) & 32'h1F) != 32'(got)) begin
          errors++;
          $display("FAIL t4_word%0d: got %h/%b required %h/%b",
                   got, ow, oe, ex.w, ex.e);
        end
        got++;
      end
      if (k >= 8) io_in_valid = 1'b0;
      else begin
        io_in_imm      = 32'(k);
        io_in_template = $urandom;
      end
    end
    checks++;
    if (got != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL t4_count: got %0d words, %0d left, required 8/0",
               got, q.size());
    end
    checks++;
    if (full_seen == 0) begin
      errors++;
      $display("FAIL t4_full: in_ready never 0 required some 0");
    end
  endtask

  task automatic test_random();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      io_in_valid    = ($urandom_range(0, 3) != 0);
      io_out_ready   = ($urandom_range(0, 2) != 0) || (c >= 480);
      if (c >= 470) io_in_valid = 1'b0;
      io_in_template = $urandom;
      io_in_imm      = rand_imm();
      io_in_imm_type = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (io_in_ready !== !(q.size() == 2 && !io_out_ready)) begin
        errors++;
        $display("FAIL rnd_in_ready: got %b with %0d in flight", io_in_ready,
                 q.size());
      end
      step(hs, ow, oe, ex);
      if (hs) begin
        checks++;
        if (!ex.v || ow !== ex.w || oe !== ex.e) begin
          errors++;
          $display("FAIL rnd_word: got %h/%b required %h/%b v=%b",
                   ow, oe, ex.w, ex.e, ex.v);
        end
      end
      checks++;
      if (io_err_sticky !== exp_sticky) begin
        errors++;
        $display("FAIL rnd_sticky: got %b required %b", io_err_sticky,
                 exp_sticky);
      end
`ifdef IMM_ENC_STATS_EN
      checks++;
      if (io_enc_count !== CW'(exp_enc) || io_err_count !== CW'(exp_errc)) begin
        errors++;
        $display("FAIL rnd_cnt: got %0d/%0d required %0d/%0d",
                 io_enc_count, io_err_count, exp_enc, exp_errc);
      end
`endif
    end
    checks++;
    if (q.size() != 0 || io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: %0d left, out_valid=%b required 0/0",
               q.size(), io_out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    int seen;
    do_reset();
    io_out_ready   = 1'b1;
    io_in_valid    = 1'b1;
    io_in_template = 32'h0000_0093;
    io_in_imm      = 32'd5;
    io_in_imm_type = 3'd3;
    step(hs, ow, oe, ex);
    io_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) step(hs, ow, oe, ex);
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    step(hs, ow, oe, ex);
    step(hs, ow, oe, ex);
    io_in_valid = 1'b0;
    #1;
    checks++;
    if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 ||
        io_err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL t5_pre: valid=%b in_ready=%b sticky=%b required 1/0/1",
               io_out_valid, io_in_ready, io_err_sticky);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    q.delete();
    exp_sticky = 1'b0;
    exp_enc = 0;
    exp_errc = 0;
    checks++;
    if (io_out_valid !== 1'b0 || io_err_sticky !== 1'b0 ||
        io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t5_post: valid=%b sticky=%b in_ready=%b required 0/0/1",
               io_out_valid, io_err_sticky, io_in_ready);
    end
`ifdef IMM_ENC_STATS_EN
    checks++;
    if (io_enc_count !== '0 || io_err_count !== '0) begin
      errors++;
      $display("FAIL t5_cnt: got %0d/%0d required 0/0",
               io_enc_count, io_err_count);
    end
`endif
    seen = 0;
    io_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (io_out_valid) seen++;
      @(posedge clock);
      #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL t5_dropped: %0d stale words emitted required 0", seen);
    end
  endtask

`ifdef IMM_ENC_STATS_EN
  task automatic test_stats();
    bit hs; logic [31:0] ow; logic oe; exp_t ex;
    int acc, cyc;
    do_reset();
    acc = 0; cyc = 0;
    io_out_ready   = 1'b1;
    io_in_valid    = 1'b1;
    io_in_template = 32'h0000_0013;
    io_in_imm_type = 3'd3;
    io_in_imm      = 32'd4;
    for (int c = 0; c < 60 && acc < 20; c++) begin
      io_in_imm = (acc == 3 || acc == 9 || acc == 15) ? 32'd0 : 32'd4;
      #1;
      if (io_in_ready) acc++;
      step(hs, ow, oe, ex);
      cyc++;
    end
    io_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step(hs, ow, oe, ex);
    checks++;
    if (cyc != 20) begin
      errors++;
      $display("FAIL t6_rate: 20 words took %0d cycles required 20", cyc);
    end
    checks++;
    if (io_enc_count !== 4'd15 || io_err_count !== 4'd3) begin
      errors++;
      $display("FAIL t6_cnt: got %0d/%0d required 15/3",
               io_enc_count, io_err_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_out_ready = 1'b0;
    test_reset();
    test_latency();
    test_s_type_err();
    test_back_to_back();
    test_stream_stall();
    test_random();
    test_reset_midflight();
`ifdef IMM_ENC_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
